// File: rtl/fsm_sensor_gen.sv
// Drives the two-bit barrier sensor bus {a,b} through a car entry or exit
// sequence with programmable per-phase dwell, abort rollback and counters.
module fsm_sensor_gen #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_ent,
  input  logic               start_sal,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sensor,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               req_err,
  output logic [CNT_W-1:0]   cnt_ent,
  output logic [CNT_W-1:0]   cnt_sal,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    TAIL = 3'd4,
    RB1  = 3'd5,
    RB2  = 3'd6
  } state_t;

  // Handshake: start_ent/start_sal are single-cycle requests, accepted only
  // while IDLE (busy=0) and ignored otherwise; completion is a done pulse
  // with aborted qualifying it. There is no backpressure on any output.

  state_t               state, state_n;
  logic [DWELL_W-1:0]   phase_cnt, phase_cnt_n;
  logic [DWELL_W-1:0]   d_lat, d_lat_n;
  logic                 dir_exit, dir_exit_n;
  logic                 abort_flag, abort_flag_n;
  logic                 done_n, aborted_n, req_err_n;
  logic [CNT_W-1:0]     cnt_ent_n, cnt_sal_n;
  logic                 phase_last;

  // Middle phases are mirrored between the two directions.
  function automatic logic [1:0] sensor_of(input state_t s, input logic exit_dir);
    logic [1:0] v;
    v = 2'b00;
    case (s)
      P1, RB1: v = exit_dir ? 2'b01 : 2'b10;
      P2, RB2: v = 2'b11;
      P3:      v = exit_dir ? 2'b10 : 2'b01;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  assign phase_last = (phase_cnt == d_lat - 1'b1);
  assign state_dbg  = state;

  always_comb begin
    state_n      = state;
    phase_cnt_n  = phase_cnt + 1'b1;
    d_lat_n      = d_lat;
    dir_exit_n   = dir_exit;
    abort_flag_n = abort_flag;
    done_n       = 1'b0;
    aborted_n    = 1'b0;
    req_err_n    = 1'b0;
    cnt_ent_n    = cnt_ent;
    cnt_sal_n    = cnt_sal;

    case (state)
      IDLE: begin
        phase_cnt_n = '0;
        if (start_ent && start_sal) begin
          req_err_n = 1'b1;
        end else if (start_ent || start_sal) begin
          state_n      = P1;
          dir_exit_n   = start_sal;
          d_lat_n      = (dwell == '0) ? DWELL_W'(1) : dwell;
          abort_flag_n = 1'b0;
        end
      end
      P1, P2, P3: begin
        if (abort) begin
          abort_flag_n = 1'b1;
          phase_cnt_n  = '0;
          case (state)
            P1:      state_n = TAIL;
            P2:      state_n = RB1;
            default: state_n = RB2;
          endcase
        end else if (phase_last) begin
          phase_cnt_n = '0;
          case (state)
            P1:      state_n = P2;
            P2:      state_n = P3;
            default: state_n = TAIL;
          endcase
        end
      end
      RB2: begin
        if (phase_last) begin
          state_n     = RB1;
          phase_cnt_n = '0;
        end
      end
      RB1: begin
        if (phase_last) begin
          state_n     = TAIL;
          phase_cnt_n = '0;
        end
      end
      TAIL: begin
        if (phase_last) begin
          state_n     = IDLE;
          phase_cnt_n = '0;
          done_n      = 1'b1;
          aborted_n   = abort_flag;
          if (!abort_flag) begin
            if (dir_exit) cnt_sal_n = cnt_sal + 1'b1;
            else          cnt_ent_n = cnt_ent + 1'b1;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        phase_cnt_n = '0;
      end
    endcase
  end

  // Sensor and busy are registered from the next state so they move on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      d_lat      <= DWELL_W'(1);
      dir_exit   <= 1'b0;
      abort_flag <= 1'b0;
      sensor     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      req_err    <= 1'b0;
      cnt_ent    <= '0;
      cnt_sal    <= '0;
    end else begin
      state      <= state_n;
      phase_cnt  <= phase_cnt_n;
      d_lat      <= d_lat_n;
      dir_exit   <= dir_exit_n;
      abort_flag <= abort_flag_n;
      sensor     <= sensor_of(state_n, dir_exit_n);
      busy       <= (state_n != IDLE);
      done       <= done_n;
      aborted    <= aborted_n;
      req_err    <= req_err_n;
      cnt_ent    <= cnt_ent_n;
      cnt_sal    <= cnt_sal_n;
    end
  end

endmodule

// File: tb/tb_fsm_sensor_gen.sv
// Directed bench for fsm_sensor_gen: sensor sequences via an expected queue,
// completion flags, counters, abort rollback, request errors and reset.
module tb_fsm_sensor_gen;

  logic       clk;
  logic       reset_n;
  logic       start_ent;
  logic       start_sal;
  logic       abort;
  logic [7:0] dwell;
  logic [1:0] sensor;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       req_err;
  logic [7:0] cnt_ent;
  logic [7:0] cnt_sal;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  fsm_sensor_gen #(.DWELL_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_ent (start_ent),
    .start_sal (start_sal),
    .abort     (abort),
    .dwell     (dwell),
    .sensor    (sensor),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .req_err   (req_err),
    .cnt_ent   (cnt_ent),
    .cnt_sal   (cnt_sal),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic ent, input logic sal, input logic [7:0] dw);
    start_ent = ent;
    start_sal = sal;
    dwell     = dw;
    tick();
    start_ent = 1'b0;
    start_sal = 1'b0;
  endtask

  task automatic push_rep(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Compares one sensor value per cycle from the current cycle onward; the
  // final tick lands just past the edge that ends the sequence.
  task automatic drain(input string tag, input int abort_idx, input bit noise);
    logic [1:0] prev;
    logic [1:0] e;
    int idx;
    prev = 2'b00;
    idx  = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sensor"}, 32'(sensor), 32'(e));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_gray"}, 32'($countones(sensor ^ prev) <= 1), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      prev  = sensor;
      abort = (idx == abort_idx);
      if (noise) begin
        start_ent = 1'b1;
        start_sal = 1'b1;
        dwell     = 8'($urandom_range(0, 255));
      end
      tick();
      abort     = 1'b0;
      start_ent = 1'b0;
      start_sal = 1'b0;
      idx++;
    end
  endtask

  task automatic expect_end(input string tag, input logic ab,
                            input logic [7:0] ce, input logic [7:0] cs);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_aborted"}, 32'(aborted), 32'(ab));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sensor_end"}, 32'(sensor), 32'd0);
    check({tag, "_cnt_ent"}, 32'(cnt_ent), 32'(ce));
    check({tag, "_cnt_sal"}, 32'(cnt_sal), 32'(cs));
  endtask

  initial begin
    reset_n   = 1'b0;
    start_ent = 1'b0;
    start_sal = 1'b0;
    abort     = 1'b0;
    dwell     = 8'd1;
    tick();
    tick();
    check("rst_sensor", 32'(sensor), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);
    check("rst_cnt_ent", 32'(cnt_ent), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: entry dwell=1; abort pulsed during TAIL must be ignored
    start_seq(1'b1, 1'b0, 8'd1);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    drain("t1", 3, 1'b0);
    expect_end("t1", 1'b0, 8'd1, 8'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_aborted_low", 32'(aborted), 32'd0);

    // 2: exit dwell=3, 12 busy cycles
    start_seq(1'b0, 1'b1, 8'd3);
    push_rep(2'b01, 3);
    push_rep(2'b11, 3);
    push_rep(2'b10, 3);
    push_rep(2'b00, 3);
    drain("t2", -1, 1'b0);
    expect_end("t2", 1'b0, 8'd1, 8'd1);
    tick();

    // 3: entry dwell=2, abort in the second cycle of P3 -> rollback
    start_seq(1'b1, 1'b0, 8'd2);
    push_rep(2'b10, 2);
    push_rep(2'b11, 2);
    push_rep(2'b01, 2);
    push_rep(2'b11, 2);
    push_rep(2'b10, 2);
    push_rep(2'b00, 2);
    drain("t3", 5, 1'b0);
    expect_end("t3", 1'b1, 8'd1, 8'd1);
    tick();
    check("t3_aborted_low", 32'(aborted), 32'd0);

    // 4: both starts in IDLE, then starts and dwell noise while busy
    start_ent = 1'b1;
    start_sal = 1'b1;
    tick();
    start_ent = 1'b0;
    start_sal = 1'b0;
    check("t4_req_err", 32'(req_err), 32'd1);
    check("t4_sensor", 32'(sensor), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_state", 32'(state_dbg), 32'd0);
    tick();
    check("t4_req_err_pulse", 32'(req_err), 32'd0);
    start_seq(1'b1, 1'b0, 8'd2);
    push_rep(2'b10, 2);
    push_rep(2'b11, 2);
    push_rep(2'b01, 2);
    push_rep(2'b00, 2);
    drain("t4n", -1, 1'b1);
    check("t4n_req_err", 32'(req_err), 32'd0);
    expect_end("t4n", 1'b0, 8'd2, 8'd1);
    tick();

    // 6: reset in the middle of P2, then a clean exit
    start_seq(1'b0, 1'b1, 8'd4);
    for (int i = 0; i < 5; i++) tick();
    check("t6_in_p2", 32'(state_dbg), 32'd2);
    check("t6_p2_sensor", 32'(sensor), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_sensor", 32'(sensor), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cnt_ent", 32'(cnt_ent), 32'd0);
    check("t6_rst_cnt_sal", 32'(cnt_sal), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    start_seq(1'b0, 1'b1, 8'd1);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    drain("t6", -1, 1'b0);
    expect_end("t6", 1'b0, 8'd0, 8'd1);

    // 5: dwell=0 acts as 1; 256 back-to-back entries wrap cnt_ent to 0.
    // Each start is raised in the cycle where done is high.
    for (int n = 0; n < 256; n++) begin
      start_seq(1'b1, 1'b0, 8'd0);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b00);
      drain("t5", -1, 1'b0);
      check("t5_done", 32'(done), 32'd1);
      if (n == 254) check("t5_cnt_255", 32'(cnt_ent), 32'd255);
    end
    check("t5_wrap", 32'(cnt_ent), 32'd0);
    check("t5_cnt_sal", 32'(cnt_sal), 32'd1);
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
